// File: rtl/icache_fetch_unit.sv
// rtl/icache_fetch_unit.sv - direct-mapped instruction cache between IF and the memory line-fetch port
module icache_fetch_unit #(
  parameter int IDX_W  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_inst,
  output logic              icache_fc_valid,
  output logic [ADDR_W-1:0] icache_fc_addr,
  input  logic              icache_fc_done,
  input  logic [127:0]      icache_fc_line
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - 4 - IDX_W;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MISS = 1'b1;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [127:0]     data [LINES];

  logic [0:0]        state;
  logic [ADDR_W-1:2] req_addr;
  logic              cancelled;

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             hit;
  logic             fill;

  assign if_idx  = if_addr[3+IDX_W:4];
  assign if_tag  = if_addr[ADDR_W-1:4+IDX_W];
  assign req_idx = req_addr[3+IDX_W:4];
  assign req_tag = req_addr[ADDR_W-1:4+IDX_W];
  assign hit     = valid[if_idx] && (tags[if_idx] == if_tag);
  assign fill    = rdy && (state == ST_MISS) && icache_fc_done;

  function automatic logic [31:0] sel_word(input logic [127:0] line, input logic [1:0] w);
    return line[32*w +: 32];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (fill) begin
      valid[req_idx] <= 1'b1;
    end
  end

  // Tag and data arrays are not reset; the valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (fill) begin
      data[req_idx] <= icache_fc_line;
      tags[req_idx] <= req_tag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_IDLE;
      req_addr        <= '0;
      cancelled       <= 1'b0;
      if_done         <= 1'b0;
      if_inst         <= '0;
      icache_fc_valid <= 1'b0;
      icache_fc_addr  <= '0;
    end else if (rdy) begin
      if_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (if_valid && !if_flush) begin
            if (hit) begin
              if_done <= 1'b1;
              if_inst <= sel_word(data[if_idx], if_addr[3:2]);
            end else begin
              icache_fc_valid <= 1'b1;
              icache_fc_addr  <= {if_addr[ADDR_W-1:4], 4'b0000};
              req_addr        <= if_addr[ADDR_W-1:2];
              cancelled       <= 1'b0;
              state           <= ST_MISS;
            end
          end
        end
        ST_MISS: begin
          if (icache_fc_done) begin
            icache_fc_valid <= 1'b0;
            // A flush in the same cycle as the returning line still suppresses delivery.
            if (!cancelled && !if_flush) begin
              if_done <= 1'b1;
              if_inst <= sel_word(icache_fc_line, req_addr[3:2]);
            end
            state <= ST_IDLE;
          end else if (if_flush) begin
            cancelled <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_fetch_unit.sv
// tb/tb_icache_fetch_unit.sv - scoreboard bench for icache_fetch_unit with a behavioural cache model
module tb_icache_fetch_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         rdy;
  logic         if_valid;
  logic [31:0]  if_addr;
  logic         if_flush;
  logic         if_done;
  logic [31:0]  if_inst;
  logic         fc_valid;
  logic [31:0]  fc_addr;
  logic         fc_done;
  logic [127:0] fc_line;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic        edge_rdy = 1'b0;

  logic        mv [16];
  logic [23:0] mt [16];

  icache_fetch_unit #(.IDX_W(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_valid(if_valid), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_inst(if_inst),
    .icache_fc_valid(fc_valid), .icache_fc_addr(fc_addr),
    .icache_fc_done(fc_done), .icache_fc_line(fc_line)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_rdy <= rdy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every fresh if_done pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (rst && edge_rdy && if_done) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_done: got %h expected no if_done at %0t", if_inst, $time);
      end else begin
        check("if_inst", if_inst, exp_q.pop_front());
      end
    end
  end

  // Backing memory: the first line carries a small program, others a hash of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] la, input logic [1:0] w);
    if (la == 32'h0000_1000) begin
      case (w)
        2'd0: return 32'h0000_0013;
        2'd1: return 32'h0010_0093;
        2'd2: return 32'h0020_0113;
        default: return 32'h0030_0193;
      endcase
    end
    return (la + 32'(w) * 4) * 32'h9E37_79B1 + 32'h1;
  endfunction

  function automatic logic [127:0] mem_line(input logic [31:0] la);
    return {mem_word(la, 2'd3), mem_word(la, 2'd2), mem_word(la, 2'd1), mem_word(la, 2'd0)};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
  endtask

  // flush_at in [0,dly] flushes that many cycles after the miss is seen; -1 means never.
  task automatic fetch(input logic [31:0] a, input int flush_at, input int dly);
    logic [31:0] la;
    int          idx;
    logic        hit;
    logic        canc;
    la  = {a[31:4], 4'b0000};
    idx = int'(a[7:4]);
    hit = mv[idx] && (mt[idx] == a[31:8]);
    if_valid = 1'b1;
    if_addr  = a;
    if (hit) begin
      exp_q.push_back(mem_word(la, a[3:2]));
      @(posedge clk); #1;
      check("hit_done", {31'd0, if_done}, 32'd1);
      check("hit_no_fc", {31'd0, fc_valid}, 32'd0);
    end else begin
      @(posedge clk); #1;
      check("miss_fc_valid", {31'd0, fc_valid}, 32'd1);
      check("miss_fc_addr", fc_addr, la);
      check("miss_no_done", {31'd0, if_done}, 32'd0);
      for (int c = 0; c < dly; c++) begin
        if (c == flush_at) begin
          if_flush = 1'b1;
          if_valid = 1'b0;
        end
        @(posedge clk); #1;
        if_flush = 1'b0;
        check("miss_fc_hold", {fc_valid, fc_addr}, {1'b1, la});
      end
      if (flush_at == dly) begin
        if_flush = 1'b1;
        if_valid = 1'b0;
      end
      canc = (flush_at >= 0) && (flush_at <= dly);
      if (!canc) exp_q.push_back(mem_word(la, a[3:2]));
      fc_line = mem_line(la);
      fc_done = 1'b1;
      @(posedge clk); #1;
      fc_done  = 1'b0;
      if_flush = 1'b0;
      check("fill_done", {31'd0, if_done}, {31'd0, !canc});
      check("fill_fc_low", {31'd0, fc_valid}, 32'd0);
      mv[idx] = 1'b1;
      mt[idx] = a[31:8];
    end
    if_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    if_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1;
    if_valid = 1'b0; if_addr = '0; if_flush = 1'b0;
    fc_done = 1'b0; fc_line = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_if_done", {31'd0, if_done}, 32'd0);
    check("rst_if_inst", if_inst, 32'd0);
    check("rst_fc_valid", {31'd0, fc_valid}, 32'd0);
    check("rst_fc_addr", fc_addr, 32'd0);
    rst = 1'b1;
    idle(1);

    // Cold miss, hit streaming, conflict eviction
    fetch(32'h0000_1008, -1, 2);
    fetch(32'h0000_1000, -1, 0);
    fetch(32'h0000_1004, -1, 0);
    fetch(32'h0000_100C, -1, 0);
    fetch(32'h0000_1100, -1, 1);
    fetch(32'h0000_1000, -1, 0);

    // Flush during a miss, then the line is present
    fetch(32'h0000_2040, 1, 3);
    idle(1);
    fetch(32'h0000_2040, -1, 0);
    idle(1);

    // Stall a hit with rdy low
    if_valid = 1'b1;
    if_addr  = 32'h0000_2040;
    rdy      = 1'b0;
    exp_q.push_back(mem_word(32'h0000_2040, 2'd0));
    repeat (3) begin
      @(posedge clk); #1;
      check("stall_no_done", {31'd0, if_done}, 32'd0);
    end
    rdy = 1'b1;
    @(posedge clk); #1;
    check("stall_done", {31'd0, if_done}, 32'd1);
    if_valid = 1'b0;
    @(posedge clk); #1;
    check("stall_single", {31'd0, if_done}, 32'd0);

    // Randomized traffic over a few tags so conflicts are frequent
    for (int n = 0; n < 300; n++) begin
      logic [23:0] tg;
      logic [31:0] a;
      int          fl;
      int          d;
      case ($urandom_range(0, 3))
        0: tg = 24'h000010;
        1: tg = 24'h000011;
        2: tg = 24'h000020;
        default: tg = 24'h00003A;
      endcase
      a  = {tg, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'b00};
      d  = $urandom_range(0, 4);
      fl = ($urandom_range(0, 4) == 0) ? $urandom_range(0, d) : -1;
      fetch(a, fl, d);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(1);

    // Reset in the middle of a miss, then a late fc_done
    fetch(32'h0000_1000, -1, 1);
    idle(1);
    if_valid = 1'b1;
    if_addr  = 32'h0000_FF00;
    @(posedge clk); #1;
    check("rmiss_fc_valid", {31'd0, fc_valid}, 32'd1);
    rst = 1'b0;
    #1;
    check("rmiss_fc_low", {31'd0, fc_valid}, 32'd0);
    check("rmiss_done_low", {31'd0, if_done}, 32'd0);
    if_valid = 1'b0;
    model_clear();
    @(posedge clk); #1;
    rst = 1'b1;
    fc_line = mem_line(32'h0000_FF00);
    fc_done = 1'b1;
    @(posedge clk); #1;
    fc_done = 1'b0;
    check("late_fc_valid", {31'd0, fc_valid}, 32'd0);
    check("late_no_done", {31'd0, if_done}, 32'd0);
    fetch(32'h0000_1000, -1, 2);
    idle(2);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache_fetch_unit.md
Name: icache_fetch_unit

Overview:
- Direct-mapped instruction cache. It sits between the instruction-fetch stage (IF) and the memory controller's icache fetch port.
- It serves 32-bit instruction reads from IF. On a miss it requests a 16-byte line through the fc_valid/fc_addr/fc_done/fc_line handshake, fills the line, then delivers the word.
- It is the initiator (requesting) end of the memory controller's line-fetch interface.

Parameters:
- IDX_W, 4: index width; the cache has 2^IDX_W lines of 128 bits each.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready; when low, all state holds.
- if_valid  in  1  IF requests an instruction. Held with if_addr until if_done or if_flush.
- if_addr  in  ADDR_W  byte address of the instruction. Bits [1:0] are always 0.
- if_flush  in  1  IF abandons its current request (branch redirect).
- if_done  out  1  one-cycle pulse; if_inst is valid in the same cycle.
- if_inst  out  32  fetched instruction word.
- icache_fc_valid  out  1  line fetch request to the memory controller.
- icache_fc_addr  out  ADDR_W  line-aligned fetch address, bits [3:0] = 0.
- icache_fc_done  in  1  one-cycle pulse from the memory controller: line delivered.
- icache_fc_line  in  128  fetched line. Byte k of the line is at bits [8k+7:8k], i.e. little-endian.

Behaviour:
- Address split:
  - word select = addr[3:2]
  - index = addr[3+IDX_W:4]
  - tag = addr[ADDR_W-1:4+IDX_W]
  - Word w of a line = line[32w+31:32w].
- Storage per line: valid bit, tag, 128-bit data. Only valid bits are cleared by reset.
- Reset (rst=0, asynchronous):
  - all valid bits cleared; state=IDLE
  - if_done=0, if_inst=0, icache_fc_valid=0, icache_fc_addr=0
- rdy=0: every register holds, including if_done/if_inst and fc_valid; no fill occurs. The memory controller also stalls on rdy, so fc_done never arrives while rdy=0.
- if_done: defaults to 0 each clocked cycle unless set below, so it is a single-cycle pulse.
- State machine, IDLE:
  - if_valid=1 and if_flush=0 and hit (valid[idx] and tag match) → next edge: if_done=1, if_inst=selected word. Stay in IDLE.
  - Hit latency is 1 cycle; back-to-back hits give 1 instruction per cycle.
  - if_valid=1 and if_flush=0 and miss → icache_fc_valid=1, icache_fc_addr = if_addr with [3:0] cleared; latch the request address; go to MISS.
  - if_flush=1 → no action.
- State machine, MISS:
  - icache_fc_valid and icache_fc_addr stay constant until icache_fc_done is sampled high.
  - On the edge that samples icache_fc_done=1:
    - icache_fc_valid=0 (it must already be low in the following cycle so the memory controller does not relaunch)
    - data[idx]=icache_fc_line, tag[idx]=latched tag, valid[idx]=1
    - if the request was not flushed: if_done=1, if_inst = word of icache_fc_line selected by the latched addr[3:2]
    - go to IDLE
  - Miss latency: if_done is asserted in the cycle after fc_done.
  - if_flush=1 during MISS: set a cancelled flag. The outstanding fetch still completes and fills the cache, but no if_done is produced.
  - if_flush and icache_fc_done in the same cycle: fill, no if_done, return to IDLE.
  - if_valid or if_addr changes during MISS are ignored until IDLE. The latched address is authoritative.
- Replacement: direct-mapped; a fill overwrites the line at that index unconditionally.
- Reset mid-MISS: request dropped, fc_valid=0 immediately (asynchronous). A late icache_fc_done after reset is ignored because the state is IDLE.
- No self-modifying-code coherence. Stores do not invalidate lines.

Test Plan:
- Cold miss: after reset, if_valid=1, if_addr=0x00001008.
  - Expect icache_fc_valid=1 with fc_addr=0x00001000 the next cycle.
  - Return fc_line={0x00300193,0x00200113,0x00100093,0x00000013} (word 3 … word 0).
  - Expect if_done=1 with if_inst=0x00200113 one cycle after fc_done, and fc_valid=0 in that cycle.
- Hit streaming: after the fill above, request 0x1000, 0x1004, 0x100C on consecutive cycles.
  - Expect if_done on 3 consecutive cycles with 0x00000013, 0x00100093, 0x00300193.
  - Expect no fc_valid.
- Conflict eviction: request 0x00001100 (same index 0, tag 0x11).
  - Expect a miss with fc_addr=0x00001100.
  - A later request to 0x00001000 misses again.
- Flush during miss: miss on 0x2040, assert if_flush 2 cycles later, then fc_done.
  - Expect no if_done.
  - Expect a subsequent 0x2040 request to hit in 1 cycle.
- Reset mid-miss: pull rst low while fc_valid=1.
  - Expect fc_valid=0 and if_done=0 immediately.
  - After release, the previously hit 0x1000 misses.
- rdy stall: hold rdy=0 across a hit request for 3 cycles.
  - Expect no if_done until the cycle after rdy returns high, then exactly one pulse.
